// File: rtl/sram_1r1w_init.sv
// 1-read/1-write SRAM with segmented write mask and a hardware zeroing sweep.
// The sweep runs after reset and on INITB; accesses are accepted only in READY.
module sram_1r1w_init #(
    parameter int BITS       = 233,
    parameter int WORD_DEPTH = 16,
    parameter int ADD_WIDTH  = 4,
    parameter int SEG        = 1,
    parameter int BYPASS     = 1
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 REB,
    input  logic                 WEB,
    input  logic [SEG-1:0]       BWEB,
    input  logic [ADD_WIDTH-1:0] AA,
    input  logic [ADD_WIDTH-1:0] AB,
    input  logic [BITS-1:0]      D,
    input  logic                 INITB,
    output logic [BITS-1:0]      Q,
    output logic                 RDY
);
    localparam int                   SW   = BITS / SEG;
    localparam logic [ADD_WIDTH-1:0] LAST = ADD_WIDTH'(WORD_DEPTH - 1);

    typedef enum logic {INIT, READY} state_e;

    state_e               state_q, state_d;
    logic [ADD_WIDTH-1:0] cnt_q, cnt_d;
    logic [BITS-1:0]      q_q, q_d;
    logic [BITS-1:0]      mem_q [WORD_DEPTH];

    logic                 aa_ok, ab_ok;
    logic [BITS-1:0]      bmask, old_word, rd_word, merged;
    logic                 wr_en;
    logic [ADD_WIDTH-1:0] wr_addr;
    logic [BITS-1:0]      wr_data;

    assign aa_ok = 32'(AA) < WORD_DEPTH;
    assign ab_ok = 32'(AB) < WORD_DEPTH;

    // Out-of-range addresses read as zero so nothing undefined reaches Q.
    assign old_word = aa_ok ? mem_q[AA] : '0;
    assign rd_word  = ab_ok ? mem_q[AB] : '0;

    always_comb begin
        bmask = '0;
        for (int k = 0; k < SEG; k++)
            bmask[k*SW +: SW] = {SW{~BWEB[k]}};
    end

    assign merged = (D & bmask) | (old_word & ~bmask);

    // Single write port shared by the sweep and external writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cnt_q;
        wr_data = '0;
        if (RSTB) begin
            if (state_q == INIT) begin
                wr_en = 1'b1;
            end else if (!WEB && aa_ok) begin
                wr_en   = 1'b1;
                wr_addr = AA;
                wr_data = merged;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (!REB && ab_ok)
                    q_d = (BYPASS != 0 && !WEB && AA == AB) ? merged : rd_word;
                if (!INITB) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= INIT;
            cnt_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    assign Q   = q_q;
    assign RDY = (state_q == READY);
endmodule

// File: tb/tb_sram_1r1w_init.sv
// Directed bench: three instances (default, 12-deep 4-segment write-first,
// 16-deep 4-segment read-first) share one stimulus stream.
module tb_sram_1r1w_init;
    logic         CLK = 1'b0;
    logic         rstb = 1'b1;
    logic         reb = 1'b1, web = 1'b1, initb = 1'b1;
    logic         bweb1 = 1'b0;
    logic [3:0]   bweb4 = 4'b0;
    logic [3:0]   aa = '0, ab = '0;
    logic [232:0] d = '0;
    logic [232:0] q0;
    logic [31:0]  q1, q2;
    logic         rdy0, rdy1, rdy2;
    int           checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    sram_1r1w_init dut0 (
        .CLK(CLK), .RSTB(rstb), .REB(reb), .WEB(web), .BWEB(bweb1), .AA(aa), .AB(ab),
        .D(d), .INITB(initb), .Q(q0), .RDY(rdy0));

    sram_1r1w_init #(.BITS(32), .WORD_DEPTH(12), .ADD_WIDTH(4), .SEG(4), .BYPASS(1)) dut1 (
        .CLK(CLK), .RSTB(rstb), .REB(reb), .WEB(web), .BWEB(bweb4), .AA(aa), .AB(ab),
        .D(d[31:0]), .INITB(initb), .Q(q1), .RDY(rdy1));

    sram_1r1w_init #(.BITS(32), .WORD_DEPTH(16), .ADD_WIDTH(4), .SEG(4), .BYPASS(0)) dut2 (
        .CLK(CLK), .RSTB(rstb), .REB(reb), .WEB(web), .BWEB(bweb4), .AA(aa), .AB(ab),
        .D(d[31:0]), .INITB(initb), .Q(q2), .RDY(rdy2));

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [232:0] data,
                      input logic [3:0] b4, input logic b1);
        web = 1'b0; aa = a; d = data; bweb4 = b4; bweb1 = b1;
        tick();
        web = 1'b1; bweb4 = 4'b0; bweb1 = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        reb = 1'b0; ab = a;
        tick();
        reb = 1'b1;
    endtask

    initial begin
        logic [31:0] exp1;
        logic [232:0] ones;
        ones = '1;

        // Reset state
        #2 rstb = 1'b0;
        repeat (3) tick();
        check("rst_q0", 256'(q0), 256'(0));
        check("rst_rdy0", 256'(rdy0), 256'(0));
        check("rst_rdy1", 256'(rdy1), 256'(0));
        rstb = 1'b1;

        // Initial sweep: RDY rises after exactly WORD_DEPTH edges
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("sweep_rdy0_%0d", k), 256'(rdy0), 256'(k == 16));
            check($sformatf("sweep_rdy1_%0d", k), 256'(rdy1), 256'(k >= 12));
        end
        rd(4'd5);
        check("rd5_q0", 256'(q0), 256'(0));
        check("rd5_q1", 256'(q1), 256'(0));

        // Segmented write mask
        wr(4'd3, ones, 4'b0000, 1'b0);
        wr(4'd3, 233'h12345678, 4'b1010, 1'b1);
        rd(4'd3);
        check("mask_q1", 256'(q1), 256'h FF34FF78);
        check("mask_q2", 256'(q2), 256'h FF34FF78);
        check("mask_q0_disabled", 256'(q0), 256'(ones));

        // Same-address collision: write-first vs read-first
        wr(4'd7, 233'hAA, 4'b0, 1'b0);
        reb = 1'b0; web = 1'b0; aa = 4'd7; ab = 4'd7; d = 233'h55;
        tick();
        reb = 1'b1; web = 1'b1;
        check("byp_q0", 256'(q0), 256'h55);
        check("byp_q1", 256'(q1), 256'h55);
        check("rdfirst_q2", 256'(q2), 256'hAA);
        rd(4'd7);
        check("after_coll_q2", 256'(q2), 256'h55);

        // Out-of-range write/read on the 12-deep instance
        wr(4'd2, 233'h3, 4'b0, 1'b0);
        rd(4'd2);
        check("set_q1", 256'(q1), 256'h3);
        wr(4'd14, 233'hDEAD, 4'b0, 1'b0);
        rd(4'd14);
        check("oor_rd_q1", 256'(q1), 256'h3);
        check("inrange_q0", 256'(q0), 256'hDEAD);
        for (int i = 0; i < 12; i++) begin
            rd(4'(i));
            exp1 = (i == 3) ? 32'hFF34FF78 : (i == 7) ? 32'h55 : (i == 2) ? 32'h3 : 32'h0;
            check($sformatf("oor_entry%0d", i), 256'(q1), 256'(exp1));
        end

        // INITB re-initialisation: accesses ignored, Q held, contents cleared
        wr(4'd1, 233'h1, 4'b0, 1'b0);
        rd(4'd1);
        check("pre_init_q0", 256'(q0), 256'h1);
        initb = 1'b0;
        tick();
        initb = 1'b1;
        check("init_rdy0", 256'(rdy0), 256'(0));
        for (int k = 1; k <= 16; k++) begin
            if (k <= 10) begin
                reb = 1'b0; ab = 4'd1; web = 1'b0; aa = 4'd1; d = 233'hFF;
                initb = (k == 5) ? 1'b0 : 1'b1;
            end
            tick();
            reb = 1'b1; web = 1'b1; initb = 1'b1;
            check($sformatf("init_rdy0_%0d", k), 256'(rdy0), 256'(k == 16));
            check($sformatf("init_q0_%0d", k), 256'(q0), 256'h1);
        end
        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
            check($sformatf("cleared%0d", i), 256'(q0), 256'(0));
        end

        // Reset mid-sweep aborts and restarts from entry 0
        wr(4'd12, 233'h9, 4'b0, 1'b0);
        rd(4'd12);
        check("pre_rst_q0", 256'(q0), 256'h9);
        initb = 1'b0;
        tick();
        initb = 1'b1;
        repeat (8) tick();
        rstb = 1'b0;
        #2;
        check("midrst_q0", 256'(q0), 256'(0));
        check("midrst_rdy0", 256'(rdy0), 256'(0));
        rstb = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("resweep_rdy0_%0d", k), 256'(rdy0), 256'(k == 16));
        end
        rd(4'd12);
        check("resweep_e12", 256'(q0), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_1r1w_init.md
SRAM_1R1W_INIT -- requirements
Module: sram_1r1w_init

Interface
REQ-001 Parameters SHALL be, one per line:
- BITS, 233, data width.
- WORD_DEPTH, 16, number of entries; need not be a power of 2.
- ADD_WIDTH, 4, address width; ceil(log2(WORD_DEPTH)) <= ADD_WIDTH.
- SEG, 1, number of write-mask segments; BITS divisible by SEG.
- BYPASS, 1, 1 = write-first on same-address collision, 0 = read-first.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- CLK, input, 1, the only clock.
- RSTB, input, 1, asynchronous active-low reset.
- REB, input, 1, read enable, active-low.
- WEB, input, 1, write enable, active-low.
- BWEB, input, SEG, per-segment write enable, active-low.
- AA, input, ADD_WIDTH, write address.
- AB, input, ADD_WIDTH, read address.
- D, input, BITS, write data.
- INITB, input, 1, re-initialise request, active-low, sampled on CLK.
- Q, output, BITS, read data (registered).
- RDY, output, 1, high when the array is initialised and accepting accesses.
REQ-003 The block SHALL use one clock (CLK) and an asynchronous active-low reset (RSTB); no other clock or reset SHALL exist.

Function
REQ-004 Storage SHALL be WORD_DEPTH x BITS; segment k covers bits [(k+1)*BITS/SEG-1 : k*BITS/SEG].
REQ-005 The FSM SHALL have two states, INIT and READY; RDY SHALL be 1 only in READY.
REQ-006 In INIT, an internal counter SHALL write all-zero to entry cnt each cycle, starting at 0 and incrementing by 1.
REQ-007 When cnt == WORD_DEPTH-1 is written, the FSM SHALL go to READY on the next edge, and cnt SHALL return to 0.
REQ-008 A full sweep SHALL take exactly WORD_DEPTH cycles; RDY SHALL rise on the edge after the last clear write.
REQ-009 In INIT, external REB, WEB and BWEB SHALL be ignored, and Q SHALL hold its value.
REQ-010 In READY, INITB == 0 at an edge SHALL move the FSM to INIT with cnt = 0; any access in that same cycle SHALL still complete.
REQ-011 INITB asserted during INIT SHALL have no effect; the sweep SHALL continue and SHALL NOT restart.
REQ-012 In READY, WEB == 0 at an edge SHALL write D into entry AA, only for segments with BWEB[k] == 0; other segments SHALL be unchanged.
REQ-013 In READY, REB == 0 at an edge SHALL load Q with entry AB; the latency SHALL be 1 cycle, with Q valid after that edge.
REQ-014 When REB == 1, or when AB >= WORD_DEPTH, Q SHALL hold its previous value.
REQ-015 A write with AA >= WORD_DEPTH SHALL be dropped without side effects.
REQ-016 Same-cycle read and write with AA == AB and BYPASS == 1: Q SHALL return the merged word, i.e. new D in enabled segments and old data elsewhere.
REQ-017 Same-cycle read and write with AA == AB and BYPASS == 0: Q SHALL return the pre-write contents.
REQ-018 For AA != AB, the read and write SHALL be independent.
REQ-019 Q SHALL never be driven with X or random data from inside the block.

Reset
REQ-020 While RSTB == 0, the following SHALL hold asynchronously: Q = 0, RDY = 0, state = INIT, cnt = 0.
REQ-021 After RSTB deasserts, the sweep SHALL start at the first CLK edge.
REQ-022 RSTB asserted mid-sweep or mid-access SHALL abort the operation and restart the sweep from entry 0.
REQ-023 Array contents SHALL NOT be reset directly; they SHALL be zeroed only by the sweep.

Verification
REQ-024 Default parameters; release RSTB. Required: RDY = 0 for 16 cycles, then 1; reading entry 5 returns Q = 0.
REQ-025 SEG = 4, BITS = 32, READY. Write 0xFFFFFFFF to entry 3 with BWEB = 4'b0000. Then write 0x12345678 to entry 3 with BWEB = 4'b1010. Required: a read of entry 3 returns 0xFF34FF78.
REQ-026 BYPASS = 1, entry 7 = 0xAA. Read and write entry 7 with D = 0x55 in the same cycle. Required: Q = 0x55 next cycle. With BYPASS = 0, the same stimulus SHALL give Q = 0xAA.
REQ-027 READY, Q = 0x1. Pulse INITB one cycle. Required: RDY = 0 for WORD_DEPTH cycles, Q stays 0x1, and all entries then read 0.
REQ-028 Assert RSTB at sweep cycle 8. Required: Q = 0 and RDY = 0 immediately; after release, RDY rises exactly 16 cycles later.
REQ-029 WORD_DEPTH = 12, ADD_WIDTH = 4. Write AA = 14, then read AB = 14 while Q = 0x3. Required: no entry changes and Q stays 0x3.
